keypad_col_decoder: RTL and testbench

KEYPAD_COL_DECODER -- requirements
Module: keypad_col_decoder

---
 rtl/keypad_pkg.sv | 51 +++++
 rtl/keypad_col_decoder_col_sync.sv | 26 ++
 rtl/keypad_col_decoder.sv | 241 ++++++++++++++++++++++++
 tb/tb_keypad_col_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad scan path (row driver and column decoder):
// FSM state encoding, key-code widths, the "no key" frame result and a helper
// that reduces one 16-key scan frame to a single result.
package keypad_pkg;

   localparam int ROW_W     = 2;                 // row index width
   localparam int NUM_ROWS  = 4;
   localparam int NUM_COLS  = 4;                 // column sense lines
   localparam int COL_IDX_W = 2;                 // column index width
   localparam int KEY_W     = ROW_W + COL_IDX_W; // {row, col} key code
   localparam int NUM_KEYS  = NUM_ROWS * NUM_COLS;

   // Frame result is one bit wider than a key code so "no key" is distinct
   // from key 0.
   typedef logic [KEY_W:0] key_res_t;
   localparam key_res_t KEY_NONE = {1'b1, {KEY_W{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DEB_PRESS = 2'd1,
      ST_PRESSED   = 2'd2,
      ST_DEB_REL   = 2'd3
   } key_state_t;

   typedef struct packed {
      key_res_t res;
      logic     multi;
   } frame_res_t;

   // Reduce a frame bitmap (bit = row*NUM_COLS + col, 1 = closed) to a result:
   // exactly one closed key gives its code, otherwise KEY_NONE; more than one
   // closed key also flags multi.
   function automatic frame_res_t decode_frame(input logic [NUM_KEYS-1:0] map);
      frame_res_t r;
      int         n;
      r.res   = KEY_NONE;
      r.multi = 1'b0;
      n       = 0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (map[i]) begin
            n     = n + 1;
            r.res = {1'b0, KEY_W'(i)};
         end
      end
      if (n != 1) r.res = KEY_NONE;
      r.multi = (n > 1);
      return r;
   endfunction

endpackage

// File: rtl/keypad_col_decoder_col_sync.sv
// col_sync
// Two-flop synchronizer for the asynchronous keypad column lines. Resets to
// all-ones, which is the "all keys open" level of the active-low columns.
module col_sync #(
   parameter int WIDTH = 4
) (
   input  logic             CLK_100HZ,
   input  logic             RESET,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta;

   // two-stage capture of the asynchronous inputs
   always_ff @(posedge CLK_100HZ or posedge RESET) begin
      if (RESET) begin
         meta     <= '1;
         sync_out <= '1;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/keypad_col_decoder.sv
// keypad_col_decoder
// Turns the scanned column lines of a 4x4 keypad into debounced key events.
// Column samples are synchronized and paired with the row that was driven when
// they were taken; four paired samples form one frame, and a press/release
// debouncer runs once per frame.
//
// Optional feature: define KEYPAD_REPEAT_EN to re-pulse KEY_VALID every
// REPEAT_FRAMES frames while a key stays held.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no key accepted, waiting for a single-key frame
// ST_DEB_PRESS | candidate key seen, counting identical frames
// ST_PRESSED   | key accepted, KEY_HELD high
// ST_DEB_REL   | accepted key missing, counting non-matching frames
module keypad_col_decoder
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int REPEAT_FRAMES   = 50
) (
   input  logic                CLK_100HZ,
   input  logic                RESET,
   input  logic [ROW_W-1:0]    ROW_IDX,
   input  logic [NUM_COLS-1:0] COL_IN,
   output logic [KEY_W-1:0]    KEY_CODE,
   output logic                KEY_VALID,
   output logic                KEY_HELD,
   output logic                MULTI_ERR
);

   if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
      $error("keypad_col_decoder: DEBOUNCE_FRAMES must be 1..15");
   end
   if (REPEAT_FRAMES < 2 || REPEAT_FRAMES > 255) begin : g_bad_repeat
      $error("keypad_col_decoder: REPEAT_FRAMES must be 2..255");
   end

   localparam logic [3:0]       DEB_CNT  = 4'(DEBOUNCE_FRAMES);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

   logic [NUM_COLS-1:0]          col_s;
   logic [NUM_COLS-1:0]          closed_now;
   logic [ROW_W-1:0]             row_d1, row_d2;
   logic                         vld_d1, vld_d2;
   logic                         frame_armed;
   logic [NUM_KEYS-NUM_COLS-1:0] key_acc;
   logic [NUM_KEYS-1:0]          frame_map;
   logic                         frame_close;
   frame_res_t                   frame_res;

   key_state_t       state, state_nx;
   logic [KEY_W-1:0] cand, cand_nx;
   logic [3:0]       deb_cnt, cnt_nx, cnt_inc;
   logic [KEY_W-1:0] code_nx;
   logic             valid_nx, held_nx, multi_nx;
   logic             res_none, match_cand, match_code;

`ifdef KEYPAD_REPEAT_EN
   localparam logic [7:0] RPT_CNT = 8'(REPEAT_FRAMES);
   logic [7:0] rpt_cnt, rpt_nx;
`endif

   col_sync #(.WIDTH(NUM_COLS)) u_col_sync (
      .CLK_100HZ (CLK_100HZ),
      .RESET     (RESET),
      .async_in  (COL_IN),
      .sync_out  (col_s)
   );

   assign closed_now = ~col_s;

   // delay the row index by the synchronizer depth so it lines up with col_s;
   // the valid bits keep reset-value rows from being mistaken for real samples
   always_ff @(posedge CLK_100HZ or posedge RESET) begin
      if (RESET) begin
         row_d1 <= '0;
         row_d2 <= '0;
         vld_d1 <= 1'b0;
         vld_d2 <= 1'b0;
      end else begin
         row_d1 <= ROW_IDX;
         row_d2 <= row_d1;
         vld_d1 <= 1'b1;
         vld_d2 <= vld_d1;
      end
   end

   // collect rows 0..2 of the frame; a frame only counts once its row 0 was
   // seen, so a reset in mid-scan never yields a partial frame
   always_ff @(posedge CLK_100HZ or posedge RESET) begin
      if (RESET) begin
         key_acc     <= '0;
         frame_armed <= 1'b0;
      end else if (vld_d2) begin
         if (row_d2 == '0) frame_armed <= 1'b1;
         case (row_d2)
            2'd0:    key_acc[3:0]  <= closed_now;
            2'd1:    key_acc[7:4]  <= closed_now;
            2'd2:    key_acc[11:8] <= closed_now;
            default: ;
         endcase
      end
   end

   // the row-3 sample is still live on col_s in the closing cycle
   assign frame_close = vld_d2 && frame_armed && (row_d2 == LAST_ROW);
   assign frame_map   = {closed_now, key_acc};
   assign frame_res   = decode_frame(frame_map);

   assign res_none   = (frame_res.res == KEY_NONE);
   assign match_cand = (frame_res.res == {1'b0, cand});
   assign match_code = (frame_res.res == {1'b0, KEY_CODE});
   assign cnt_inc    = (deb_cnt == 4'hF) ? deb_cnt : deb_cnt + 4'd1;

   // debouncer next state and outputs, evaluated only at frame close
   always_comb begin
      state_nx = state;
      cand_nx  = cand;
      cnt_nx   = deb_cnt;
      code_nx  = KEY_CODE;
      valid_nx = 1'b0;
      held_nx  = KEY_HELD;
      multi_nx = frame_close && frame_res.multi;
`ifdef KEYPAD_REPEAT_EN
      rpt_nx   = rpt_cnt;
`endif
      if (frame_close) begin
         case (state)
            ST_IDLE: begin
               if (!res_none) begin
                  cand_nx = frame_res.res[KEY_W-1:0];
                  cnt_nx  = 4'd1;
                  if (DEBOUNCE_FRAMES == 1) begin
                     state_nx = ST_PRESSED;
                     code_nx  = frame_res.res[KEY_W-1:0];
                     valid_nx = 1'b1;
                     held_nx  = 1'b1;
                     cnt_nx   = 4'd0;
`ifdef KEYPAD_REPEAT_EN
                     rpt_nx   = 8'd0;
`endif
                  end else begin
                     state_nx = ST_DEB_PRESS;
                  end
               end
            end
            ST_DEB_PRESS: begin
               if (res_none) begin
                  state_nx = ST_IDLE;
                  cnt_nx   = 4'd0;
               end else if (match_cand) begin
                  cnt_nx = cnt_inc;
                  if (cnt_inc >= DEB_CNT) begin
                     state_nx = ST_PRESSED;
                     code_nx  = cand;
                     valid_nx = 1'b1;
                     held_nx  = 1'b1;
                     cnt_nx   = 4'd0;
`ifdef KEYPAD_REPEAT_EN
                     rpt_nx   = 8'd0;
`endif
                  end
               end else begin
                  cand_nx = frame_res.res[KEY_W-1:0];
                  cnt_nx  = 4'd1;
               end
            end
            ST_PRESSED: begin
               if (match_code) begin
`ifdef KEYPAD_REPEAT_EN
                  if (rpt_cnt + 8'd1 >= RPT_CNT) begin
                     rpt_nx   = 8'd0;
                     valid_nx = 1'b1;
                  end else begin
                     rpt_nx = rpt_cnt + 8'd1;
                  end
`endif
               end else if (DEBOUNCE_FRAMES == 1) begin
                  state_nx = ST_IDLE;
                  held_nx  = 1'b0;
                  cnt_nx   = 4'd0;
               end else begin
                  state_nx = ST_DEB_REL;
                  cnt_nx   = 4'd1;
               end
            end
            ST_DEB_REL: begin
               if (match_code) begin
                  state_nx = ST_PRESSED;
                  cnt_nx   = 4'd0;
`ifdef KEYPAD_REPEAT_EN
                  rpt_nx   = 8'd0;
`endif
               end else begin
                  cnt_nx = cnt_inc;
                  if (cnt_inc >= DEB_CNT) begin
                     state_nx = ST_IDLE;
                     held_nx  = 1'b0;
                     cnt_nx   = 4'd0;
                  end
               end
            end
            default: begin
               state_nx = ST_IDLE;
               cnt_nx   = 4'd0;
            end
         endcase
      end
   end

   // debouncer state and registered outputs
   always_ff @(posedge CLK_100HZ or posedge RESET) begin
      if (RESET) begin
         state     <= ST_IDLE;
         cand      <= '0;
         deb_cnt   <= 4'd0;
         KEY_CODE  <= '0;
         KEY_VALID <= 1'b0;
         KEY_HELD  <= 1'b0;
         MULTI_ERR <= 1'b0;
      end else begin
         state     <= state_nx;
         cand      <= cand_nx;
         deb_cnt   <= cnt_nx;
         KEY_CODE  <= code_nx;
         KEY_VALID <= valid_nx;
         KEY_HELD  <= held_nx;
         MULTI_ERR <= multi_nx;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   // frames held since entering PRESSED (or since the last repeat pulse)
   always_ff @(posedge CLK_100HZ or posedge RESET) begin
      if (RESET) rpt_cnt <= 8'd0;
      else       rpt_cnt <= rpt_nx;
   end
`endif

endmodule

// File: tb/tb_keypad_col_decoder.sv
// tb_keypad_col_decoder
// Drives a simulated 4x4 keypad frame by frame (a 16-bit set of closed keys
// held for whole scan frames) and compares the decoder outputs every cycle
// against a frame-level run-length model of press/release debouncing.
// Honours KEYPAD_REPEAT_EN (repeat period 4 in that build).
module tb_keypad_col_decoder;
   import keypad_pkg::*;

   localparam int TB_DEB = 3;
`ifdef KEYPAD_REPEAT_EN
   localparam int TB_RPT = 4;
`else
   localparam int TB_RPT = 50;
`endif

   logic       CLK_100HZ = 1'b0;
   logic       RESET     = 1'b0;
   logic [1:0] ROW_IDX   = 2'd3;
   logic [3:0] COL_IN    = 4'hF;
   logic [3:0] KEY_CODE;
   logic       KEY_VALID, KEY_HELD, MULTI_ERR;

   keypad_col_decoder #(
      .DEBOUNCE_FRAMES (TB_DEB),
      .REPEAT_FRAMES   (TB_RPT)
   ) dut (
      .CLK_100HZ (CLK_100HZ),
      .RESET     (RESET),
      .ROW_IDX   (ROW_IDX),
      .COL_IN    (COL_IN),
      .KEY_CODE  (KEY_CODE),
      .KEY_VALID (KEY_VALID),
      .KEY_HELD  (KEY_HELD),
      .MULTI_ERR (MULTI_ERR)
   );

   always #5 CLK_100HZ = ~CLK_100HZ;

   int vectors     = 0;
   int miscompares = 0;

   // keypad and model state
   logic [15:0] keys      = 16'h0;
   logic [15:0] next_keys = 16'h0;
   int          cur_row   = 3;
   bit          armed, p1_vld, p2_vld;
   logic [15:0] p1_map, p2_map;
   bit          m_held;
   int          m_code, run_key, run_len, miss, rpt;
   logic [3:0]  exp_code;
   logic        exp_valid, exp_held, exp_multi;
   int          m_valid_cnt = 0, m_multi_cnt = 0;
   int          d_valid_cnt = 0, d_multi_cnt = 0;
   bit          checking = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison, away from the active edge
   always @(negedge CLK_100HZ) begin
      if (checking) begin
         check("key_code",  int'(KEY_CODE),  int'(exp_code));
         check("key_valid", int'(KEY_VALID), int'(exp_valid));
         check("key_held",  int'(KEY_HELD),  int'(exp_held));
         check("multi_err", int'(MULTI_ERR), int'(exp_multi));
         if (KEY_VALID === 1'b1) d_valid_cnt++;
         if (MULTI_ERR === 1'b1) d_multi_cnt++;
      end
   end

   task automatic model_reset();
      exp_code = 4'd0; exp_valid = 1'b0; exp_held = 1'b0; exp_multi = 1'b0;
      m_held = 0; m_code = 0; run_key = 0; run_len = 0; miss = 0; rpt = 0;
      armed = 0; p1_vld = 0; p2_vld = 0; p1_map = '0; p2_map = '0;
   endtask

   // one closed frame: single key -> its code, else none; >1 keys -> multi
   task automatic model_frame(input logic [15:0] map);
      int n;
      int r;
      n = $countones(map);
      r = -1;
      if (n > 1) begin
         exp_multi = 1'b1;
         m_multi_cnt++;
      end
      if (n == 1) begin
         for (int i = 0; i < 16; i++) if (map[i]) r = i;
      end
      if (!m_held) begin
         if (r < 0)                          run_len = 0;
         else if (run_len > 0 && r == run_key) run_len++;
         else begin
            run_key = r;
            run_len = 1;
         end
         if (run_len >= TB_DEB) begin
            m_held = 1; m_code = run_key; exp_valid = 1'b1; m_valid_cnt++;
            run_len = 0; miss = 0; rpt = 0;
         end
      end else if (r == m_code) begin
         if (miss > 0) rpt = 0;
         else begin
            rpt++;
`ifdef KEYPAD_REPEAT_EN
            if (rpt >= TB_RPT) begin
               rpt = 0; exp_valid = 1'b1; m_valid_cnt++;
            end
`endif
         end
         miss = 0;
      end else begin
         miss++;
         if (miss >= TB_DEB) begin
            m_held = 0; run_len = 0; miss = 0;
         end
      end
      exp_held = m_held;
      exp_code = 4'(m_code);
   endtask

   // one clock: the edge captures the sample of cur_row; a frame's result
   // appears two edges after its row-3 sample is captured
   task automatic tick();
      @(posedge CLK_100HZ);
      #1;
      if (RESET) model_reset();
      else begin
         exp_valid = 1'b0;
         exp_multi = 1'b0;
         if (p2_vld) model_frame(p2_map);
         p2_vld = p1_vld;
         p2_map = p1_map;
         p1_vld = 0;
         if (cur_row == 0) armed = 1;
         if (cur_row == 3 && armed) begin
            p1_vld = 1;
            p1_map = keys;
         end
      end
      cur_row = (cur_row + 1) % 4;
      ROW_IDX = 2'(cur_row);
      if (cur_row == 0) keys = next_keys;
      COL_IN = ~keys[cur_row*4 +: 4];
   endtask

   // apply a key set for n whole frames (entered and left with row 3 active)
   task automatic run_frames(input logic [15:0] set, input int n);
      next_keys = set;
      repeat (4 * n) tick();
   endtask

   // one-cycle reset inside a frame; that frame is discarded
   task automatic reset_pulse();
      tick();
      RESET = 1'b1;
      model_reset();
      tick();
      RESET = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int v0, dv0, m0, dm0;
      logic [15:0] s;
      int k, a, b;

      #1;
      RESET = 1'b1;
      model_reset();
      checking = 1;
      repeat (4) tick();
      RESET = 1'b0;

      // key 6 (row 1, col 2) for 5 frames: one press
      v0 = m_valid_cnt; dv0 = d_valid_cnt;
      run_frames(16'h0040, 5);
      run_frames(16'h0000, 4);
      check("k6 model presses", m_valid_cnt - v0, 1);
      check("k6 dut presses",   d_valid_cnt - dv0, 1);
      check("k6 code kept",     int'(KEY_CODE), 6);

      // key 9 bounce: 1 closed, 1 open, 3 closed
      v0 = m_valid_cnt; dv0 = d_valid_cnt;
      run_frames(16'h0200, 1);
      run_frames(16'h0000, 1);
      run_frames(16'h0200, 3);
      run_frames(16'h0000, 4);
      check("k9 model presses", m_valid_cnt - v0, 1);
      check("k9 dut presses",   d_valid_cnt - dv0, 1);
      check("k9 code kept",     int'(KEY_CODE), 9);

      // keys 0 and 5 together for 4 frames
      v0 = m_valid_cnt; dv0 = d_valid_cnt; m0 = m_multi_cnt; dm0 = d_multi_cnt;
      run_frames(16'h0021, 4);
      run_frames(16'h0000, 4);
      check("multi model pulses", m_multi_cnt - m0, 4);
      check("multi dut pulses",   d_multi_cnt - dm0, 4);
      check("multi dut presses",  d_valid_cnt - dv0, 0);
      check("multi model presses", m_valid_cnt - v0, 0);

      // key 10 for one frame short of the debounce count
      v0 = m_valid_cnt; dv0 = d_valid_cnt;
      run_frames(16'h0400, 2);
      run_frames(16'h0000, 4);
      check("short model presses", m_valid_cnt - v0, 0);
      check("short dut presses",   d_valid_cnt - dv0, 0);

      // key 15 held, released 2 frames, closed again
      v0 = m_valid_cnt; dv0 = d_valid_cnt;
      run_frames(16'h8000, 4);
      run_frames(16'h0000, 2);
      run_frames(16'h8000, 3);
      check("k15 still held", int'(KEY_HELD), 1);
      run_frames(16'h0000, 4);
      check("k15 model presses", m_valid_cnt - v0, 1);
      check("k15 dut presses",   d_valid_cnt - dv0, 1);
      check("k15 released",      int'(KEY_HELD), 0);

      // key 3 held, reset mid-press, still held afterwards
      v0 = m_valid_cnt; dv0 = d_valid_cnt;
      run_frames(16'h0008, 4);
      reset_pulse();
      run_frames(16'h0008, 4);
      run_frames(16'h0000, 4);
      check("k3 model presses", m_valid_cnt - v0, 2);
      check("k3 dut presses",   d_valid_cnt - dv0, 2);
      check("k3 code kept",     int'(KEY_CODE), 3);

`ifdef KEYPAD_REPEAT_EN
      // key 12 held 15 frames: pulses at closes 3, 7, 11, 15
      v0 = m_valid_cnt; dv0 = d_valid_cnt;
      run_frames(16'h1000, 15);
      run_frames(16'h0000, 4);
      check("k12 model repeats", m_valid_cnt - v0, 4);
      check("k12 dut repeats",   d_valid_cnt - dv0, 4);
`endif

      // randomized runs of none / single keys from a small pool / key pairs
      for (int i = 0; i < 90; i++) begin
         k = $urandom_range(0, 9);
         if (k < 3) s = 16'h0;
         else if (k < 8) s = 16'd1 << ($urandom_range(0, 3) * 5);
         else begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            s = (16'd1 << a) | (16'd1 << b);
         end
         run_frames(s, $urandom_range(1, 5));
      end
      run_frames(16'h0000, 4);

      checking = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
